// File: rtl/dec_2to4_hs.sv
// dec_2to4_hs: registered SEL_W-to-2**SEL_W one-hot decoder with a
// valid/ready handshake on both sides. A one-entry skid register gives
// full throughput while keeping in_ready a registered signal.
//
// Optional build macro: DEC_HIT_CNT_EN
//   When defined, adds cnt_clr input, hit_cnt output and per-line
//   saturating transfer counters (CNT_W bits each).
module dec_2to4_hs #(
    parameter int SEL_W = 2,
`ifdef DEC_HIT_CNT_EN
    parameter int CNT_W = 8,
`endif
    localparam int OUT_W = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_en,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef DEC_HIT_CNT_EN
    input  logic               cnt_clr,
    output logic [OUT_W*CNT_W-1:0] hit_cnt,
`endif
    output logic [OUT_W-1:0]   out
);

    // EMPTY: nothing held; ONE: output register full; TWO: skid also full
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [OUT_W-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [OUT_W-1:0]   dec_word;
    logic               accept;
    logic               xfer;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out       = out_q;

    // Decode, handshake qualification and next-state/datapath selection
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        skid_d   = skid_q;
        dec_word = in_en ? (OUT_W'(1) << in_sel) : '0;
        accept   = in_valid && in_ready_q;
        xfer     = (state_q != ST_EMPTY) && out_ready;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = dec_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    // Output drains and reloads in the same edge: no bubble
                    out_d = dec_word;
                end else if (accept) begin
                    skid_d  = dec_word;
                    state_d = ST_TWO;
                end else if (xfer) begin
                    out_d   = '0;
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a transfer can happen
                if (xfer) begin
                    out_d   = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                out_d   = '0;
                skid_d  = '0;
            end
        endcase

        // Registered ready: low only while the skid will be holding a word
        in_ready_d = (state_d != ST_TWO);
    end

    // State, data and ready registers; reset discards everything held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef DEC_HIT_CNT_EN
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_hit
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Count transfers with this line set; clear wins, saturate at max
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if (xfer && out_q[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Counter register
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_dec_2to4_hs.sv
// Testbench for dec_2to4_hs: directed steps from the test plan followed by
// random traffic, checked against a queue-based model of words in flight.
module tb_dec_2to4_hs;

    localparam int SEL_W = 2;
    localparam int OUT_W = 4;
`ifdef DEC_HIT_CNT_EN
    localparam int CNT_W = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
`ifdef DEC_HIT_CNT_EN
    logic             cnt_clr;
    logic [OUT_W*CNT_W-1:0] hit_cnt;
    int               cnt_m [OUT_W];
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [OUT_W-1:0] q [$];   // words accepted and not yet transferred

    always #5 clk = ~clk;

    dec_2to4_hs #(
        .SEL_W(SEL_W)
`ifdef DEC_HIT_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sel(in_sel),
        .in_en(in_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef DEC_HIT_CNT_EN
        .cnt_clr(cnt_clr),
        .hit_cnt(hit_cnt),
`endif
        .out(out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample handshake mid-cycle, advance the
    // model at the edge and compare the DUT against it just after.
    task automatic cycle(input logic v, input int sel, input logic en, input logic ordy);
        logic acc, xfr;
        logic [OUT_W-1:0] w;
        in_valid  = v;
        in_sel    = SEL_W'(sel);
        in_en     = en;
        out_ready = ordy;
        @(negedge clk);
        acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        xfr = (out_valid === 1'b1) && (out_ready === 1'b1);
        w   = en ? OUT_W'(2**sel) : '0;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
`ifdef DEC_HIT_CNT_EN
            foreach (cnt_m[i]) cnt_m[i] = 0;
`endif
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out", 32'(out), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
        end else begin
            if (xfr && q.size() > 0) begin
`ifdef DEC_HIT_CNT_EN
                for (int i = 0; i < OUT_W; i++)
                    if (q[0][i] && cnt_m[i] < 2**CNT_W - 1) cnt_m[i]++;
`endif
                void'(q.pop_front());
            end
            if (acc) q.push_back(w);
`ifdef DEC_HIT_CNT_EN
            if (cnt_clr) foreach (cnt_m[i]) cnt_m[i] = 0;
            for (int i = 0; i < OUT_W; i++)
                check($sformatf("hit_cnt[%0d]", i), 32'(hit_cnt[i*CNT_W +: CNT_W]), 32'(cnt_m[i]));
`endif
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) check("out", 32'(out), 32'(q[0]));
            $display("t=%0t v=%0b sel=%0d en=%0b ordy=%0b acc=%0b xfer=%0b -> out_valid=%0b out=%b in_ready=%0b held=%0d",
                     $time, v, sel, en, ordy, acc, xfr, out_valid, out, in_ready, q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_en = 1'b0; out_ready = 1'b0;
`ifdef DEC_HIT_CNT_EN
        cnt_clr = 1'b0;
        foreach (cnt_m[i]) cnt_m[i] = 0;
`endif
        // Reset for 3 cycles, with a pending producer that must be ignored
        for (int i = 0; i < 3; i++) cycle(1'b1, 3, 1'b1, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b1);                   // in_ready rises

        // Back-to-back stream with consumer ready
        for (int s = 0; s < 4; s++) cycle(1'b1, s, 1'b1, 1'b1);
        cycle(1'b1, 2, 1'b0, 1'b1);                   // disabled decode -> 0000
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);

        // Stall: fill output and skid, hold, then drain in order
        cycle(1'b1, 1, 1'b1, 1'b0);
        cycle(1'b1, 3, 1'b1, 1'b0);
        cycle(1'b1, 0, 1'b1, 1'b0);                   // refused: in_ready low
        cycle(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1);

        // Reset with skid full discards both words
        cycle(1'b1, 2, 1'b1, 1'b0);
        cycle(1'b1, 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, 0, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1);

`ifdef DEC_HIT_CNT_EN
        // Saturation of one line, then clear
        cnt_clr = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 2, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 0, 1'b0, 1'b1);
        check("hit_sat_slice2", 32'(hit_cnt[2*CNT_W +: CNT_W]), 32'd3);
        cnt_clr = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b1);
        cnt_clr = 1'b0;
        check("hit_clr_all", 32'(hit_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
